// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit front end: register offsets,
// STATUS/CTRL bit positions and the drain state machine encoding.
package uart_tx_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_TMO   = 4;
    localparam int ST_LEVEL = 8;

    localparam int CTRL_DRAIN = 0;
    localparam int CTRL_FLUSH = 1;
    localparam int CTRL_CLR   = 2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock DEPTH x 8 byte FIFO with synchronous flush that overrides
// both push and pop in the same cycle.
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [7:0]      wr_data,
    output logic [7:0]      rd_data,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] level
);

    localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);

    logic [7:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              do_push_s;
    logic              do_pop_s;

    // Qualify requests against the pre-edge occupancy
    always_comb begin
        do_push_s = push & (count_r != CNT_DEPTH) & ~flush;
        do_pop_s  = pop & (count_r != CNT_ZERO) & ~flush;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; occupancy gates every read so contents need no reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = (count_r == CNT_DEPTH);
    assign empty   = (count_r == CNT_ZERO);
    assign level   = count_r;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// APB transmit front end: register decode, byte FIFO and the drain FSM that
// hands bytes to the UART transmitter over tx_start/tx_busy.
module uart_tx_fifo_ctrl #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        irq_tx_empty
);
    import uart_tx_pkg::*;

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_ZERO = CNT_W'(0);

    tx_state_e        state_r;
    logic [7:0]       tx_data_r;
    logic             tx_start_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             drain_en_r;
    logic             overflow_r;
    logic             timeout_r;

    logic             acc_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic [1:0]       reg_sel_s;
    logic             push_s;
    logic             pop_s;
    logic             flush_s;
    logic             clr_s;
    logic             ovf_set_s;
    logic             tmo_hit_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [ADDR_W:0]  fifo_level_s;
    logic [7:0]       fifo_rd_data_s;
    logic [31:0]      status_s;
    logic [31:0]      prdata_s;
    logic             pslverr_s;
    logic             unused_s;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (PCLK),
        .rst_n   (PRESET),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (flush_s),
        .wr_data (PWDATA[7:0]),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s)
    );

    // APB access decode and the strobes derived from it
    always_comb begin
        acc_s     = PSEL & PENABLE;
        wr_acc_s  = acc_s & PWRITE;
        rd_acc_s  = acc_s & ~PWRITE;
        reg_sel_s = PADDR[3:2];
        push_s    = wr_acc_s & (reg_sel_s == REG_DATA);
        ovf_set_s = push_s & fifo_full_s;
        flush_s   = wr_acc_s & (reg_sel_s == REG_CTRL) & PWDATA[CTRL_FLUSH];
        clr_s     = wr_acc_s & (reg_sel_s == REG_CTRL) & PWDATA[CTRL_CLR];
        // A flush in the same cycle wins over the pop, so nothing is launched
        pop_s     = (state_r == S_IDLE) & drain_en_r & ~fifo_empty_s & ~tx_busy & ~flush_s;
        tmo_hit_s = (state_r == S_WAIT_BUSY) & ~tx_busy & (tmo_cnt_r == TMO_LAST);
    end

    // STATUS word, read mux and error response
    always_comb begin
        status_s                              = 32'h0000_0000;
        status_s[ST_FULL]                     = fifo_full_s;
        status_s[ST_EMPTY]                    = fifo_empty_s;
        status_s[ST_BUSY]                     = (state_r != S_IDLE);
        status_s[ST_OVF]                      = overflow_r;
        status_s[ST_TMO]                      = timeout_r;
        status_s[ST_LEVEL+ADDR_W:ST_LEVEL]    = fifo_level_s;
        prdata_s                              = 32'h0000_0000;
        pslverr_s                             = 1'b0;
        if (acc_s && PRESET) begin
            case (reg_sel_s)
                REG_DATA: begin
                    pslverr_s = wr_acc_s & fifo_full_s;
                end
                REG_STATUS: begin
                    prdata_s = rd_acc_s ? status_s : 32'h0000_0000;
                end
                REG_CTRL: begin
                    prdata_s = rd_acc_s ? {31'h0000_0000, drain_en_r} : 32'h0000_0000;
                end
                default: begin
                    pslverr_s = 1'b1;
                end
            endcase
        end else begin
            prdata_s  = 32'h0000_0000;
            pslverr_s = 1'b0;
        end
    end

    // Control register and sticky error flags; a fresh event beats a clear
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            drain_en_r <= 1'b0;
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            if (wr_acc_s && (reg_sel_s == REG_CTRL)) begin
                drain_en_r <= PWDATA[CTRL_DRAIN];
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (clr_s) begin
                overflow_r <= 1'b0;
            end
            if (tmo_hit_s) begin
                timeout_r <= 1'b1;
            end else if (clr_s) begin
                timeout_r <= 1'b0;
            end
        end
    end

    // Drain FSM: pop, pulse tx_start, wait for the transmitter to take and finish the byte
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_r    <= S_IDLE;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            tmo_cnt_r  <= TMO_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    tx_start_r <= 1'b0;
                    if (pop_s) begin
                        tx_data_r  <= fifo_rd_data_s;
                        tx_start_r <= 1'b1;
                        state_r    <= S_START;
                    end
                end
                S_START: begin
                    tx_start_r <= 1'b0;
                    tmo_cnt_r  <= TMO_ZERO;
                    state_r    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_r <= S_WAIT_DONE;
                    end else if (tmo_hit_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    tx_start_r <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

    assign PRDATA       = prdata_s;
    assign PREADY       = acc_s;
    assign PSLVERR      = pslverr_s;
    assign tx_data      = tx_data_r;
    assign tx_start     = tx_start_r;
    assign irq_tx_empty = fifo_empty_s & (state_r == S_IDLE);
    assign unused_s     = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:8]};

endmodule
